// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: splits a 32-bit load/store into two 16-bit
// SRAM accesses (low half first) and freezes the pipeline until it completes.
module mem_sram_ctrl #(
    parameter int BASE_ADDR    = 1024,
    parameter int PHASE_CYCLES = 2,
    parameter int SRAM_AW      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r,
    input  logic               mem_w,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [31:0] BASE = 32'(BASE_ADDR);
    localparam logic [3:0]  LAST = 4'(PHASE_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic               req;
    logic               phase_end;
    logic [31:0]        off;
    logic [SRAM_AW-2:0] word_q;
    logic [15:0]        wdata_hi;
    logic               op_q;

    assign req       = mem_r | mem_w;
    assign off       = addr - BASE;
    assign phase_end = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                freeze = req;
                if (req) begin
                    state_next = LO;
                    cnt_next   = 4'd0;
                end
            end
            LO: begin
                freeze = 1'b1;
                if (phase_end) begin
                    state_next = HI;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            HI: begin
                freeze = 1'b1;
                if (phase_end) begin
                    state_next = DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
        if (rst) freeze = 1'b0;
    end

    // SRAM bus and load data are registered so each half is stable for its whole phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata       <= 32'd0;
            ready       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            word_q      <= '0;
            wdata_hi    <= 16'd0;
            op_q        <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        word_q     <= off[SRAM_AW:2];
                        wdata_hi   <= wdata[31:16];
                        op_q       <= mem_w;
                        sram_addr  <= {off[SRAM_AW:2], 1'b0};
                        sram_dq_oe <= mem_w;
                        sram_we_n  <= ~mem_w;
                        if (mem_w) sram_dq_out <= wdata[15:0];
                    end
                end
                LO: begin
                    if (phase_end) begin
                        sram_addr <= {word_q, 1'b1};
                        if (op_q) sram_dq_out <= wdata_hi;
                        else      rdata[15:0] <= sram_dq_in;
                    end
                end
                HI: begin
                    if (phase_end) begin
                        ready      <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!op_q) rdata[31:16] <= sram_dq_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: directed accesses push expected load data
// and ready cycle; a negedge monitor pops and compares on every ready pulse.
module tb_mem_sram_ctrl;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w;
    logic [31:0] addr, wdata, rdata;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        p1_mem_r;
    logic [31:0] p1_addr, p1_rdata;
    logic        p1_ready, p1_freeze;
    logic [17:0] p1_sram_addr;
    logic [15:0] p1_dq_out, p1_dq_in;
    logic        p1_dq_oe, p1_we_n;

    logic [15:0] mem [0:63];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_ready_cyc = 0;

    mem_sram_ctrl dut (
        .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    mem_sram_ctrl #(.PHASE_CYCLES(1)) dut_p1 (
        .clk(clk), .rst(rst), .mem_r(p1_mem_r), .mem_w(1'b0), .addr(p1_addr),
        .wdata(32'd0), .rdata(p1_rdata), .ready(p1_ready), .freeze(p1_freeze),
        .sram_addr(p1_sram_addr), .sram_dq_out(p1_dq_out), .sram_dq_oe(p1_dq_oe),
        .sram_dq_in(p1_dq_in), .sram_we_n(p1_we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: asynchronous read, write on the clock while we_n is low.
    assign sram_dq_in = mem[sram_addr[5:0]];
    assign p1_dq_in   = mem[p1_sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1) begin
            last_ready_cyc = cyc;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready: got ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                check_output("rdata", rdata, e.rdata);
                check_output("ready_cycle", cyc, e.cyc);
            end
        end
        if (p1_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL p1_unexpected_ready: got ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                check_output("p1_rdata", p1_rdata, e.rdata);
                check_output("p1_ready_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one access on the default-phase controller starting in the current
    // cycle and traces the SRAM bus each cycle until the done cycle has passed.
    task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] exp_rdata,
                                  input logic [17:0] lo);
        int p = 2;
        mem_r = r;
        mem_w = w;
        addr  = a;
        wdata = d;
        q0.push_back('{exp_rdata, cyc + 2 * p + 1});
        for (int c = 0; c <= 2 * p + 1; c++) begin
            @(negedge clk);
            check_output("freeze", freeze, (c <= 2 * p));
            if (c >= 1 && c <= 2 * p) begin
                check_output("sram_addr", sram_addr, lo + ((c > p) ? 18'd1 : 18'd0));
                check_output("sram_we_n", sram_we_n, !w);
                check_output("sram_dq_oe", sram_dq_oe, w);
                if (w) check_output("sram_dq_out", sram_dq_out, (c > p) ? d[31:16] : d[15:0]);
            end else if (c == 2 * p + 1) begin
                check_output("done_we_n", sram_we_n, 1'b1);
                check_output("done_dq_oe", sram_dq_oe, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        mem_r = 1'b0;
        mem_w = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[2] = 16'h9ABC;
        mem[3] = 16'h1357;
        rst = 1'b1;
        mem_r = 1'b0; mem_w = 1'b0; addr = 32'd0; wdata = 32'd0;
        p1_mem_r = 1'b0; p1_addr = 32'd0;

        repeat (2) @(negedge clk);
        check_output("reset_rdata", rdata, 32'd0);
        check_output("reset_ready", ready, 1'b0);
        check_output("reset_freeze", freeze, 1'b0);
        check_output("reset_sram_addr", sram_addr, 18'd0);
        check_output("reset_dq_out", sram_dq_out, 16'd0);
        check_output("reset_dq_oe", sram_dq_oe, 1'b0);
        check_output("reset_we_n", sram_we_n, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1032 -> SRAM words 4/5.
        apply_stimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0000_0000, 18'd4);
        check_output("mem4", mem[4], 16'hBEEF);
        check_output("mem5", mem[5], 16'hDEAD);

        // Load it back.
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 18'd4);

        // Back-to-back store then load, no idle gap.
        t0 = cyc;
        apply_stimulus(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 32'hDEADBEEF, 18'd6);
        apply_stimulus(1'b1, 1'b0, 32'd1036, 32'h0, 32'hCAFEF00D, 18'd6);
        check_output("b2b_span", last_ready_cyc - t0, 32'd11);

        // Read and write together: the store wins, rdata holds.
        apply_stimulus(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hCAFEF00D, 18'd0);
        check_output("mem0", mem[0], 16'h5678);
        check_output("mem1", mem[1], 16'h1234);

        // Asynchronous reset during cycle 2 of a store at 1040 (words 8/9).
        mem_w = 1'b1; addr = 32'd1040; wdata = 32'hA5A55A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_output("abort_freeze", freeze, 1'b0);
        check_output("abort_ready", ready, 1'b0);
        check_output("abort_rdata", rdata, 32'd0);
        check_output("abort_sram_addr", sram_addr, 18'd0);
        check_output("abort_dq_out", sram_dq_out, 16'd0);
        check_output("abort_dq_oe", sram_dq_oe, 1'b0);
        check_output("abort_we_n", sram_we_n, 1'b1);
        mem_w = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_output("post_reset_ready", ready, 1'b0);
            check_output("post_reset_freeze", freeze, 1'b0);
        end
        check_output("mem8_partial", mem[8], 16'h5A5A);
        check_output("mem9_untouched", mem[9], 16'h0000);
        @(posedge clk); #1;

        // Single-cycle phases: load from 1028 -> words 2/3.
        p1_mem_r = 1'b1;
        p1_addr  = 32'd1028;
        q1.push_back('{32'h13579ABC, cyc + 3});
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check_output("p1_freeze", p1_freeze, (c <= 2));
            check_output("p1_we_n", p1_we_n, 1'b1);
            check_output("p1_dq_oe", p1_dq_oe, 1'b0);
            if (c == 1) check_output("p1_sram_addr_lo", p1_sram_addr, 18'd2);
            if (c == 2) check_output("p1_sram_addr_hi", p1_sram_addr, 18'd3);
        end
        @(posedge clk); #1;
        p1_mem_r = 1'b0;

        repeat (4) @(posedge clk);
        check_output("q0_drained", q0.size(), 32'd0);
        check_output("q1_drained", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage controller between the EXE/MEM pipeline register outputs and the board's 16-bit external SRAM.
- Converts a 32-bit load or store into two sequenced 16-bit SRAM accesses, low half first.
- Drives freeze to hold the pipeline registers until the access completes.
- Returns the assembled 32-bit load data to the MEM/WB path.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- PHASE_CYCLES, 2: clock cycles per 16-bit half access. Legal range 1..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_r  in  1  load request (MEM_R from EXE/MEM register)
- mem_w  in  1  store request (MEM_W from EXE/MEM register)
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (Rm value)
- rdata  out  32  assembled load data
- ready  out  1  access complete, single-cycle pulse
- freeze  out  1  combinational stall to all pipeline registers
- sram_addr  out  SRAM_AW  SRAM word address
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  write-data drive enable; top level builds the tristate
- sram_dq_in  in  16  SRAM read data
- sram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- States: IDLE, LO, HI, DONE. Phase counter is 4 bits.
- Reset (async) forces:
  - state=IDLE, counter=0
  - rdata=0, ready=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1
  - freeze forced 0 while rst=1
- Reset mid-access aborts immediately and returns to IDLE. The partial write is not undone.
- Request acceptance, in IDLE when req = mem_r|mem_w:
  - Latch addr, wdata, and op = mem_w at the clock edge, then go to LO with counter=0.
  - If mem_r and mem_w are both 1, the store wins.
- Address mapping:
  - off = addr - BASE_ADDR (32-bit, wrap allowed).
  - word = off[SRAM_AW:2], so addr[1:0] is ignored.
  - LO uses sram_addr = {word[SRAM_AW-2:0],1'b0}; HI uses {word[SRAM_AW-2:0],1'b1}.
  - Bits of off above SRAM_AW are ignored; no range check.
- LO and HI each last exactly PHASE_CYCLES cycles. The counter advances LO to HI, then HI to DONE, and clears on each phase change.
- Stores:
  - LO drives sram_dq_out=wdata[15:0]; HI drives wdata[31:16].
  - sram_dq_oe=1 and sram_we_n=0 for every cycle of LO and HI.
  - sram_addr and sram_dq_out are registered and stable for the whole phase.
- Loads:
  - sram_we_n=1 and sram_dq_oe=0 throughout.
  - sram_dq_in is sampled on the last cycle of LO into rdata[15:0], and on the last cycle of HI into rdata[31:16].
  - On a store, rdata keeps its previous value.
- DONE lasts 1 cycle:
  - ready=1, freeze=0, SRAM signals idle (we_n=1, oe=0).
  - Always goes to IDLE; a request still present in DONE is not re-accepted.
  - The pipeline advances on this edge.
- freeze:
  - IDLE: freeze = mem_r|mem_w.
  - LO or HI: freeze = 1.
  - DONE: freeze = 0.
- Latency: request first seen at cycle 0 gives freeze high for cycles 0..2·PHASE_CYCLES and ready at cycle 2·PHASE_CYCLES+1. With the default this is 5 stall cycles and ready at cycle 5.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. Minimum spacing is 2·PHASE_CYCLES+2 cycles.
- No request in IDLE: freeze=0, ready=0, outputs held.

Test Plan:
1. Store, addr=1032, wdata=0xDEADBEEF, PHASE_CYCLES=2:
   - Cycles 1-2: sram_addr=4, dq_out=0xBEEF, we_n=0.
   - Cycles 3-4: sram_addr=5, dq_out=0xDEAD, we_n=0.
   - freeze=1 for cycles 0-4; ready=1 only in cycle 5.
2. Load from addr=1032 with an SRAM model preloaded from scenario 1:
   - rdata=0xDEADBEEF when ready=1.
   - we_n=1 and dq_oe=0 throughout.
3. Back-to-back store then load held by freeze:
   - The second access starts in the cycle after DONE.
   - Exactly one ready per access; total 12 cycles for two accesses.
4. mem_r=mem_w=1, addr=1024, wdata=0x12345678:
   - Store performed: sram_addr 0 gets 0x5678, sram_addr 1 gets 0x1234.
   - rdata unchanged.
5. Reset asserted at cycle 2 of a store:
   - All outputs at reset values in the same cycle, state=IDLE, freeze=0.
   - After release with no request, ready stays 0.
6. PHASE_CYCLES=1, load from addr=1028:
   - sram_addr 2 then 3.
   - freeze high for 3 cycles, ready at cycle 3.
